load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory responder for the core's load/store control outputs: `memWrite`, `loadCtrl`, `storeCtrl`.
- Takes one memory operation from the execute stage. Turns it into a word-aligned bus transaction with byte enables, waits for the bus handshake, and returns a sign- or zero-extended load result.
- Sits between the ALU address output and the data-memory bus. Stalls the core while a transaction is outstanding.

Parameters:
- `ADDR_W`, 32, byte address width.
- `TIMEOUT_CYCLES`, 255, bus watchdog limit; used only when `LSU_TIMEOUT_EN` is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- reqValid  input  1  core presents a memory operation.
- reqReady  output  1  LSU idle and able to accept.
- memWrite  input  1  1 = store, 0 = load.
- loadCtrl  input  3  funct3 load encoding: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- storeCtrl  input  2  store encoding: SB=00, SH=01, SW=10.
- addr  input  ADDR_W  byte address from the ALU.
- storeData  input  32  rs2 value.
- doneValid  output  1  one-cycle completion pulse.
- loadData  output  32  extended load result; valid with doneValid.
- misaligned  output  1  set with doneValid when the access was misaligned.
- busError  output  1  set with doneValid when the watchdog fired.
- busValid  output  1  bus request valid.
- busReady  input  1  bus accepts the request.
- busWrite  output  1  bus request is a write.
- busAddr  output  ADDR_W  word-aligned address; bits [1:0] are always 0.
- busByteEn  output  4  byte-lane enables.
- busWData  output  32  lane-replicated store data.
- busRValid  input  1  read response valid.
- busRData  input  32  read response word.

Behaviour:
- Reset values: state IDLE; reqReady=1; doneValid, misaligned, busError, busValid, busWrite = 0; busAddr, busByteEn, busWData, loadData = 0.
- States:
  - IDLE: reqReady=1. When reqValid=1, register the operation.
    - Misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0) goes to DONE with misaligned=1. No bus activity.
    - Otherwise go to REQ.
  - REQ: busValid=1; the request is held stable until busReady=1.
    - busReady with store goes to DONE.
    - busReady with load goes to RESP.
  - RESP: on busRValid, capture the lane-selected, extended busRData into loadData and go to DONE.
  - DONE: doneValid=1 for exactly one cycle, then IDLE. reqReady=0 in every state except IDLE.
- Latencies:
  - Zero-wait store: accept → doneValid 2 cycles later.
  - Zero-wait load, with busRValid the cycle after busReady: 3 cycles.
- Byte enables:
  - SB: 0001 shifted left by addr[1:0].
  - SH: 0011 shifted left by addr[1].
  - SW: 1111.
- busWData: the byte (or halfword) is replicated to all lanes.
- Load extract: select the lane by addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Invalid loadCtrl/storeCtrl codes are treated as LW/SW.
- busRValid outside RESP is ignored. busReady outside REQ is ignored.
- Reset mid-transaction: at the next edge go to IDLE with busValid=0. A late response arriving afterwards is ignored.
- Error flags (misaligned, busError) are valid only while doneValid=1 and are 0 otherwise.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8..16-bit counter runs in REQ/RESP and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, drop busValid and go to DONE with busError=1; loadData=0.
- Undefined: no counter. The LSU waits indefinitely and busError is tied 0.

Decomposition:
- Shared package/include `lsu_pkg` holds:
  - Load/store encoding constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encoding: IDLE, REQ, RESP, DONE.
  - Misalignment check function.
- One combinational sub-module, `lsu_align`, covers byte-enable and write-data lane generation and load extraction/extension.
- The FSM stays in the top module.

Test Plan:
- SB at addr 0x1003, storeData 0x000000A5, busReady held 1 → busByteEn=1000, busWData=0xA5A5A5A5, busAddr=0x1000, doneValid 2 cycles after accept.
- LB at addr 0x2002, busRData=0x1280FF34 → loadData=0xFFFFFF80; LBU at the same address → 0x00000080.
- LH at addr 0x0001 → no busValid, doneValid with misaligned=1 one cycle after accept; LW at 0x0006 → same behaviour.
- LW with busReady low for 5 cycles, then busRValid 3 cycles later → busAddr/busByteEn stable throughout REQ, loadData=busRData, reqReady low until IDLE.
- Reset asserted in RESP, then busRValid pulses → state IDLE, no doneValid, loadData stays 0.
- LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, busReady never asserted → doneValid with busError=1 after 8 REQ cycles, busValid deasserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: load/store encodings, FSM state encoding and access-size helpers
// shared by the load/store unit and its lane-alignment datapath.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Unknown load/store codes fall back to a full word access.
    function automatic lsu_size_e access_size(input logic       is_store,
                                              input logic [2:0] load_ctrl,
                                              input logic [1:0] store_ctrl);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (store_ctrl)
                SB:      sz = SZ_BYTE;
                SH:      sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (load_ctrl)
                LB, LBU: sz = SZ_BYTE;
                LH, LHU: sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e  sz,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic -- byte enables and replicated write
// data for stores, lane selection and sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] byte_lane;
    logic [15:0] half_lane;

    // Lane generation and load extraction for the access size.
    always_comb begin
        byte_en_o   = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        byte_lane   = rdata_i >> {addr_lo_i, 3'b000};
        half_lane   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                byte_en_o   = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane[7:0]};
            end
            SZ_HALF: begin
                byte_en_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
            end
            default: begin
                byte_en_o   = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: accepts one load/store from execute, issues a word-aligned
// bus transaction and returns the extended load result with a done pulse.
// Defining LSU_TIMEOUT_EN adds a bus watchdog that ends a stuck transaction
// with busError after TIMEOUT_CYCLES cycles in REQ or RESP.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              memWrite,
    input  logic [2:0]        loadCtrl,
    input  logic [1:0]        storeCtrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       storeData,
    output logic              doneValid,
    output logic [31:0]       loadData,
    output logic              misaligned,
    output logic              busError,
    output logic              busValid,
    input  logic              busReady,
    output logic              busWrite,
    output logic [ADDR_W-1:0] busAddr,
    output logic [3:0]        busByteEn,
    output logic [31:0]       busWData,
    input  logic              busRValid,
    input  logic [31:0]       busRData
);

    // state | meaning
    // IDLE  | ready for a new operation
    // REQ   | bus request held until busReady
    // RESP  | load waiting for busRValid
    // DONE  | one-cycle completion pulse

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    lsu_size_e         size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic [31:0]       load_q, load_d;

    lsu_size_e         req_size;
    logic [3:0]        align_be;
    logic [31:0]       align_wdata;
    logic [31:0]       align_load;
    logic              tmo_hit;

    assign req_size = access_size(memWrite, loadCtrl, storeCtrl);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // The counter holds the number of completed cycles spent in the current
    // state, so the watchdog fires on the TIMEOUT_CYCLES-th cycle.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and error flag next-state.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if ((state_d == state_q) && ((state_q == REQ) || (state_q == RESP))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == IDLE) begin
            err_d = 1'b0;
        end else if ((state_q == REQ && !busReady && tmo_hit) ||
                     (state_q == RESP && !busRValid && tmo_hit)) begin
            err_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign busError = doneValid & err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit            = 1'b0;
    assign busError           = 1'b0;
`endif

    lsu_align u_align (
        .size_i       (size_q),
        .sign_ext_i   (sext_q),
        .addr_lo_i    (addr_q[1:0]),
        .store_data_i (wdata_q),
        .rdata_i      (busRData),
        .byte_en_o    (align_be),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load)
    );

    // Next-state: operation capture, bus handshake tracking, load capture.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        load_d  = load_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    write_d = memWrite;
                    size_d  = req_size;
                    sext_d  = ~loadCtrl[2];
                    addr_d  = addr;
                    wdata_d = storeData;
                    mis_d   = is_misaligned(req_size, addr[1:0]);
                    load_d  = '0;
                    state_d = is_misaligned(req_size, addr[1:0]) ? DONE : REQ;
                end
            end
            REQ: begin
                if (busReady) begin
                    state_d = write_q ? DONE : RESP;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            RESP: begin
                if (busRValid) begin
                    load_d  = align_load;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operation registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= SZ_WORD;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            load_q  <= load_d;
        end
    end

    // Bus fields are zero whenever no request is being presented.
    assign reqReady   = (state_q == IDLE);
    assign doneValid  = (state_q == DONE);
    assign busValid   = (state_q == REQ);
    assign busWrite   = busValid & write_q;
    assign busAddr    = busValid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign busByteEn  = busValid ? align_be : 4'b0000;
    assign busWData   = busWrite ? align_wdata : 32'h0;
    assign misaligned = doneValid & mis_q;
    assign loadData   = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus randomized operations checked
// against an arithmetic reference model of the load/store behaviour.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        memWrite;
    logic [2:0]  loadCtrl;
    logic [1:0]  storeCtrl;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busReady;
    logic        busRValid;
    logic [31:0] busRData;
    logic        reqReady, doneValid, misaligned, busError, busValid, busWrite;
    logic [31:0] loadData, busAddr, busWData;
    logic [3:0]  busByteEn;

    int n_pass  = 0;
    int n_total = 0;

    // observations of the most recent run_op
    int          o_lat, o_reqcyc;
    logic        o_mis, o_err, o_saw, o_wr, o_stable, o_ready_ok, o_flags_ok;
    logic [31:0] o_ld, o_addr, o_wd;
    logic [3:0]  o_be;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .memWrite(memWrite), .loadCtrl(loadCtrl), .storeCtrl(storeCtrl),
        .addr(addr), .storeData(storeData), .doneValid(doneValid),
        .loadData(loadData), .misaligned(misaligned), .busError(busError),
        .busValid(busValid), .busReady(busReady), .busWrite(busWrite),
        .busAddr(busAddr), .busByteEn(busByteEn), .busWData(busWData),
        .busRValid(busRValid), .busRData(busRData)
    );

    // Issue one operation and act as the bus: busReady after rw request
    // cycles, busRValid rv cycles after the handshake. With noise, stray
    // busRValid/busReady pulses are driven where they must be ignored.
    task automatic run_op(input logic wr, input logic [2:0] lc, input logic [1:0] sc,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int rw, input int rv, input bit noise);
        int c, req_seen, resp_idx;
        bit hs, done;
        o_lat = -1; o_mis = 1'bx; o_err = 1'bx; o_ld = 'x; o_saw = 0; o_wr = 0;
        o_addr = 0; o_be = 0; o_wd = 0; o_stable = 1; o_ready_ok = 1; o_flags_ok = 1;
        reqValid = 1; memWrite = wr; loadCtrl = lc; storeCtrl = sc; addr = a; storeData = sd;
        if (reqReady !== 1'b1) o_ready_ok = 0;
        @(posedge clk); #1;
        reqValid = 0; memWrite = $urandom; loadCtrl = $urandom; storeCtrl = $urandom;
        addr = $urandom; storeData = $urandom;
        c = 1; hs = 0; done = 0; req_seen = 0; resp_idx = 0;
        while (!done && c <= 300) begin
            busReady = 0; busRValid = 0; busRData = $urandom;
            if (doneValid === 1'b1) begin
                o_lat = c; o_mis = misaligned; o_err = busError; o_ld = loadData;
                if (busValid !== 1'b0) o_flags_ok = 0;
                done = 1;
            end else begin
                if (misaligned !== 1'b0 || busError !== 1'b0) o_flags_ok = 0;
                if (reqReady !== 1'b0) o_ready_ok = 0;
                if (busValid === 1'b1) begin
                    if (!o_saw) begin
                        o_saw = 1; o_addr = busAddr; o_be = busByteEn; o_wd = busWData; o_wr = busWrite;
                    end else if (busAddr !== o_addr || busByteEn !== o_be ||
                                 busWData !== o_wd || busWrite !== o_wr) begin
                        o_stable = 0;
                    end
                    if (req_seen >= rw) begin busReady = 1; hs = 1; end
                    else if (noise) busRValid = 1;
                    req_seen++;
                end else if (hs && !wr) begin
                    if (resp_idx == rv) begin busRValid = 1; busRData = rd; end
                    else if (noise) busReady = 1;
                    resp_idx++;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        o_reqcyc = req_seen;
        busReady = 0; busRValid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1; reqValid = 0; memWrite = 0; loadCtrl = 0; storeCtrl = 0; addr = 0;
        storeData = 0; busReady = 0; busRValid = 0; busRData = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        n_total++; if (reqReady !== 1'b1) $display("FAIL rst_reqReady got %b want 1", reqReady); else n_pass++;
        n_total++; if ({doneValid, misaligned, busError, busValid, busWrite} !== 5'b0)
            $display("FAIL rst_flags got %b want 00000", {doneValid, misaligned, busError, busValid, busWrite}); else n_pass++;
        n_total++; if ({busAddr, busByteEn, busWData, loadData} !== 100'b0)
            $display("FAIL rst_data addr=%h be=%b wd=%h ld=%h want all 0", busAddr, busByteEn, busWData, loadData); else n_pass++;
    endtask

    task automatic test_store_byte();
        run_op(1, 3'b000, 2'b00, 32'h0000_1003, 32'h0000_00A5, 0, 0, 0, 0);
        n_total++; if (o_be !== 4'b1000) $display("FAIL sb_be got %b want 1000", o_be); else n_pass++;
        n_total++; if (o_wd !== 32'hA5A5A5A5) $display("FAIL sb_wdata got %h want a5a5a5a5", o_wd); else n_pass++;
        n_total++; if (o_addr !== 32'h1000) $display("FAIL sb_addr got %h want 00001000", o_addr); else n_pass++;
        n_total++; if (o_lat !== 2) $display("FAIL sb_latency got %0d want 2", o_lat); else n_pass++;
        n_total++; if (o_wr !== 1'b1 || o_mis !== 1'b0) $display("FAIL sb_flags wr=%b mis=%b want 1 0", o_wr, o_mis); else n_pass++;
    endtask

    task automatic test_load_byte();
        run_op(0, 3'b000, 2'b00, 32'h0000_2002, 0, 32'h1280FF34, 0, 0, 0);
        n_total++; if (o_ld !== 32'hFFFFFF80) $display("FAIL lb_data got %h want ffffff80", o_ld); else n_pass++;
        n_total++; if (o_lat !== 3) $display("FAIL lb_latency got %0d want 3", o_lat); else n_pass++;
        run_op(0, 3'b100, 2'b00, 32'h0000_2002, 0, 32'h1280FF34, 0, 0, 0);
        n_total++; if (o_ld !== 32'h00000080) $display("FAIL lbu_data got %h want 00000080", o_ld); else n_pass++;
    endtask

    task automatic test_misaligned();
        run_op(0, 3'b001, 2'b00, 32'h0000_0001, 0, 0, 0, 0, 0);
        n_total++; if (o_lat !== 1 || o_mis !== 1'b1 || o_saw !== 1'b0)
            $display("FAIL lh_mis lat=%0d mis=%b bus=%b want 1 1 0", o_lat, o_mis, o_saw); else n_pass++;
        run_op(0, 3'b010, 2'b00, 32'h0000_0006, 0, 0, 0, 0, 0);
        n_total++; if (o_lat !== 1 || o_mis !== 1'b1 || o_saw !== 1'b0)
            $display("FAIL lw_mis lat=%0d mis=%b bus=%b want 1 1 0", o_lat, o_mis, o_saw); else n_pass++;
    endtask

    task automatic test_wait_states();
        run_op(0, 3'b010, 2'b00, 32'h3000_0008, 0, 32'hDEADBEEF, 5, 2, 0);
        n_total++; if (o_stable !== 1'b1 || o_addr !== 32'h3000_0008 || o_be !== 4'b1111)
            $display("FAIL ws_req stable=%b addr=%h be=%b want 1 30000008 1111", o_stable, o_addr, o_be); else n_pass++;
        n_total++; if (o_reqcyc !== 6) $display("FAIL ws_reqcycles got %0d want 6", o_reqcyc); else n_pass++;
        n_total++; if (o_ld !== 32'hDEADBEEF) $display("FAIL ws_data got %h want deadbeef", o_ld); else n_pass++;
        n_total++; if (o_lat !== 10) $display("FAIL ws_latency got %0d want 10", o_lat); else n_pass++;
        n_total++; if (o_ready_ok !== 1'b1 || reqReady !== 1'b1)
            $display("FAIL ws_reqReady busy_ok=%b idle=%b want 1 1", o_ready_ok, reqReady); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        reqValid = 1; memWrite = 0; loadCtrl = 3'b010; addr = 32'h40;
        @(posedge clk); #1;
        reqValid = 0; busReady = 1;
        @(posedge clk); #1;
        busReady = 0;
        n_total++; if (reqReady !== 1'b0 || busValid !== 1'b0)
            $display("FAIL rm_inresp reqReady=%b busValid=%b want 0 0", reqReady, busValid); else n_pass++;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        n_total++; if (reqReady !== 1'b1 || busValid !== 1'b0)
            $display("FAIL rm_idle reqReady=%b busValid=%b want 1 0", reqReady, busValid); else n_pass++;
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            busRValid = 1; busRData = 32'h12345678;
            @(posedge clk); #1;
            if (doneValid !== 1'b0) saw_done = 1;
        end
        busRValid = 0;
        n_total++; if (saw_done !== 1'b0) $display("FAIL rm_nodone got %b want 0", saw_done); else n_pass++;
        n_total++; if (loadData !== 32'h0) $display("FAIL rm_loaddata got %h want 0", loadData); else n_pass++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_op(0, 3'b010, 2'b00, 32'h80, 0, 0, 100000, 0, 0);
        n_total++; if (o_lat !== 9 || o_reqcyc !== 8)
            $display("FAIL tmo_latency lat=%0d reqcyc=%0d want 9 8", o_lat, o_reqcyc); else n_pass++;
        n_total++; if (o_err !== 1'b1 || o_ld !== 32'h0 || o_flags_ok !== 1'b1)
            $display("FAIL tmo_flags err=%b ld=%h ok=%b want 1 0 1", o_err, o_ld, o_flags_ok); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic wr; logic [2:0] lc; logic [1:0] sc;
        logic [31:0] a, sd, rd, exp_ld, exp_wd, v;
        logic [3:0] exp_be;
        int sz, rw, rv, exp_lat;
        bit exp_mis, sgn, noise;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1)); lc = 3'($urandom_range(0, 7)); sc = 2'($urandom_range(0, 3));
            a = $urandom; sd = $urandom; rd = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            rw = $urandom_range(0, 4); rv = $urandom_range(0, 4); noise = 1'($urandom_range(0, 1));
            if (wr) sz = (sc == 0) ? 1 : (sc == 1) ? 2 : 4;
            else    sz = (lc == 0 || lc == 4) ? 1 : (lc == 1 || lc == 5) ? 2 : 4;
            sgn = (lc == 0 || lc == 1);
            exp_mis = (a % sz) != 0;
            exp_lat = exp_mis ? 1 : wr ? rw + 2 : rw + rv + 3;
            exp_be = 4'(((1 << sz) - 1) << (a % 4));
            exp_wd = (sz == 1) ? (sd & 32'hFF) * 32'h01010101 :
                     (sz == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
            v = rd >> (8 * (a % 4));
            if (sz == 1) begin
                v = v & 32'hFF; if (sgn && v >= 128) v = v + 32'hFFFFFF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF; if (sgn && v >= 32768) v = v + 32'hFFFF0000;
            end
            exp_ld = v;
            run_op(wr, lc, sc, a, sd, rd, rw, rv, noise);
            n_total++; if (o_lat !== exp_lat) $display("FAIL rnd%0d_latency got %0d want %0d", i, o_lat, exp_lat); else n_pass++;
            n_total++; if (o_mis !== exp_mis || o_err !== 1'b0)
                $display("FAIL rnd%0d_flags mis=%b err=%b want %b 0", i, o_mis, o_err, exp_mis); else n_pass++;
            n_total++; if (o_saw !== !exp_mis) $display("FAIL rnd%0d_busseen got %b want %b", i, o_saw, !exp_mis); else n_pass++;
            n_total++; if (o_ready_ok !== 1'b1 || o_flags_ok !== 1'b1)
                $display("FAIL rnd%0d_handshake ready_ok=%b flags_ok=%b want 1 1", i, o_ready_ok, o_flags_ok); else n_pass++;
            if (!exp_mis) begin
                n_total++; if (o_addr !== (a & 32'hFFFFFFFC) || o_wr !== wr || o_stable !== 1'b1)
                    $display("FAIL rnd%0d_req addr=%h wr=%b st=%b want %h %b 1", i, o_addr, o_wr, o_stable, a & 32'hFFFFFFFC, wr); else n_pass++;
                n_total++; if (o_reqcyc !== rw + 1) $display("FAIL rnd%0d_reqcycles got %0d want %0d", i, o_reqcyc, rw + 1); else n_pass++;
                if (wr) begin
                    n_total++; if (o_be !== exp_be || o_wd !== exp_wd)
                        $display("FAIL rnd%0d_store be=%b wd=%h want %b %h", i, o_be, o_wd, exp_be, exp_wd); else n_pass++;
                end else begin
                    n_total++; if (o_ld !== exp_ld) $display("FAIL rnd%0d_load got %h want %h", i, o_ld, exp_ld); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_misaligned();
        test_wait_states();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
